// File: rtl/oflow_mem_buffer_pkg.sv
// Shared types and width helpers for the oflow history-frame buffer.
package oflow_mem_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_DONE_W = 3'd3,
    ST_DONE_R = 3'd4
  } state_t;

  // $clog2 that never returns 0, so single-entry ranges still get a 1-bit index.
  function automatic int min1_clog2(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Index width of a frame slot in the ring.
  function automatic int slot_w_of(input int num_frames);
    return min1_clog2(num_frames);
  endfunction

  // Width of a per-frame word count (0 .. max_bbox inclusive).
  function automatic int word_idx_w_of(input int max_bbox);
    return $clog2(max_bbox + 1);
  endfunction

  // Address width of one lane bank holding every slot's beats.
  function automatic int beat_addr_w_of(input int num_frames, input int max_bbox,
                                        input int num_ch);
    return min1_clog2(num_frames * max_bbox / num_ch);
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/oflow_mem_buffer_bank.sv
// Single-port synchronous RAM for one PE lane; read data is registered.
module oflow_mem_buffer_bank
  import oflow_mem_buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 80,
  parameter int ADDR_W = min1_clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write when enabled, otherwise read; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    else    rdata     <= mem[addr];
  end

endmodule

// File: rtl/oflow_mem_buffer_multi_ch.sv
// History-frame ring buffer: captures NUM_CH words per beat into per-lane
// banks and streams the stored frames back newest first.
// Handshake: a write beat transfers on a cycle where data_in_valid && in_ready;
// read beats have no back-pressure and are valid exactly when lane_valid != 0.
module oflow_mem_buffer_multi_ch
  import oflow_mem_buffer_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int MAX_BBOX   = 32,
  parameter int NUM_FRAMES = 5
) (
  input  logic                              clk,
  input  logic                              reset_N,
  input  logic                              start_write,
  input  logic                              start_read,
  input  logic [$clog2(MAX_BBOX+1)-1:0]     num_of_bbox_in_frame,
  input  logic [$clog2(NUM_FRAMES+1)-1:0]   num_of_history_frames,
  input  logic [NUM_CH*DATA_W-1:0]          data_in,
  input  logic                              data_in_valid,
  output logic                              in_ready,
  output logic [NUM_CH*DATA_W-1:0]          data_out,
  output logic [NUM_CH-1:0]                 lane_valid,
  output logic [$clog2(NUM_FRAMES)-1:0]     out_frame_age,
  output logic                              done_write,
  output logic                              done_read,
  output logic [$clog2(NUM_FRAMES+1)-1:0]   counter_of_history_frame_to_interface,
  output state_t                            dbg_state
);

  localparam int WORD_IDX_W     = word_idx_w_of(MAX_BBOX);
  localparam int HIST_W         = $clog2(NUM_FRAMES + 1);
  localparam int AGE_W          = $clog2(NUM_FRAMES);
  localparam int SLOT_W         = slot_w_of(NUM_FRAMES);
  localparam int BEATS_PER_SLOT = MAX_BBOX / NUM_CH;
  localparam int BANK_DEPTH     = NUM_FRAMES * BEATS_PER_SLOT;
  localparam int BEAT_ADDR_W    = beat_addr_w_of(NUM_FRAMES, MAX_BBOX, NUM_CH);
  localparam int BEAT_CNT_W     = $clog2(BEATS_PER_SLOT + 1);

  state_t                  state;
  logic [SLOT_W-1:0]       wr_slot;
  logic [HIST_W-1:0]       hist_cnt;
  logic [WORD_IDX_W-1:0]   bbox_cnt [NUM_FRAMES];
  logic [WORD_IDX_W-1:0]   wr_n;
  logic [BEAT_CNT_W-1:0]   wr_beat;
  logic [AGE_W-1:0]        rd_age;
  logic [BEAT_CNT_W-1:0]   rd_beat;
  logic [HIST_W-1:0]       rd_frames;
  logic                    rd_any;

  int                      h_now, n_now, wr_beats, rd_beats, srch_from, srch_lim;
  logic [SLOT_W-1:0]       rd_slot;
  logic [NUM_CH-1:0]       rd_lane_mask, bank_we;
  logic [BEAT_ADDR_W-1:0]  bank_addr;
  logic                    nxt_found;
  logic [AGE_W-1:0]        nxt_age;
  logic [DATA_W-1:0]       bank_rdata [NUM_CH];

  assign in_ready  = (state == ST_WRITE);
  assign dbg_state = state;
  assign counter_of_history_frame_to_interface = hist_cnt;

  // Clamped inputs, beat counts and the slot/lane mask of the current read beat.
  always_comb begin
    h_now    = (int'(num_of_history_frames) < NUM_FRAMES) ? int'(num_of_history_frames) : NUM_FRAMES;
    n_now    = (int'(num_of_bbox_in_frame) < MAX_BBOX) ? int'(num_of_bbox_in_frame) : MAX_BBOX;
    wr_beats = ceil_div(int'(wr_n), NUM_CH);
    rd_slot  = SLOT_W'((int'(wr_slot) + NUM_FRAMES - 1 - int'(rd_age)) % NUM_FRAMES);
    rd_beats = ceil_div(int'(bbox_cnt[rd_slot]), NUM_CH);
    for (int k = 0; k < NUM_CH; k++) begin
      rd_lane_mask[k] = (int'(rd_beat) * NUM_CH + k) < int'(bbox_cnt[rd_slot]);
      bank_we[k]      = (state == ST_WRITE) && data_in_valid &&
                        ((int'(wr_beat) * NUM_CH + k) < int'(wr_n));
    end
    if (state == ST_WRITE)
      bank_addr = BEAT_ADDR_W'(int'(wr_slot) * BEATS_PER_SLOT + int'(wr_beat));
    else
      bank_addr = BEAT_ADDR_W'(int'(rd_slot) * BEATS_PER_SLOT + int'(rd_beat));
  end

  // Find the next non-empty age so empty slots cost no cycles between beats.
  always_comb begin
    nxt_found = 1'b0;
    nxt_age   = '0;
    if (state == ST_READ) begin
      srch_from = int'(rd_age) + 1;
      srch_lim  = int'(rd_frames);
    end else begin
      srch_from = 0;
      srch_lim  = (int'(hist_cnt) < h_now) ? int'(hist_cnt) : h_now;
    end
    for (int a = NUM_FRAMES - 1; a >= 0; a--) begin
      if (a >= srch_from && a < srch_lim &&
          bbox_cnt[SLOT_W'((int'(wr_slot) + NUM_FRAMES - 1 - a) % NUM_FRAMES)] != '0) begin
        nxt_found = 1'b1;
        nxt_age   = AGE_W'(a);
      end
    end
  end

  // Control FSM: sequences writes/reads, commits frames, pulses done flags.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      state      <= ST_IDLE;
      wr_slot    <= '0;
      hist_cnt   <= '0;
      wr_n       <= '0;
      wr_beat    <= '0;
      rd_age     <= '0;
      rd_beat    <= '0;
      rd_frames  <= '0;
      rd_any     <= 1'b0;
      done_write <= 1'b0;
      done_read  <= 1'b0;
      for (int s = 0; s < NUM_FRAMES; s++) bbox_cnt[s] <= '0;
    end else begin
      done_write <= 1'b0;
      done_read  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_write) begin
            wr_n    <= WORD_IDX_W'(n_now);
            wr_beat <= '0;
            state   <= ST_WRITE;
          end else if (start_read) begin
            rd_frames <= HIST_W'(srch_lim);
            rd_any    <= nxt_found;
            rd_age    <= nxt_age;
            rd_beat   <= '0;
            state     <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (wr_n == '0) begin
            state      <= ST_DONE_W;
            done_write <= 1'b1;
          end else if (data_in_valid) begin
            if (int'(wr_beat) == wr_beats - 1) begin
              state      <= ST_DONE_W;
              done_write <= 1'b1;
            end else begin
              wr_beat <= wr_beat + 1'b1;
            end
          end
        end
        ST_DONE_W: begin
          bbox_cnt[wr_slot] <= wr_n;
          wr_slot  <= (int'(wr_slot) == NUM_FRAMES - 1) ? '0 : wr_slot + 1'b1;
          hist_cnt <= (int'(hist_cnt) + 1 > h_now) ? HIST_W'(h_now) : hist_cnt + 1'b1;
          state    <= ST_IDLE;
        end
        ST_READ: begin
          if (!rd_any) begin
            state     <= ST_DONE_R;
            done_read <= 1'b1;
          end else if (int'(rd_beat) == rd_beats - 1) begin
            if (nxt_found) begin
              rd_age  <= nxt_age;
              rd_beat <= '0;
            end else begin
              rd_any    <= 1'b0;
              state     <= ST_DONE_R;
              done_read <= 1'b1;
            end
          end else begin
            rd_beat <= rd_beat + 1'b1;
          end
        end
        ST_DONE_R: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Beat qualifiers track the bank's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset_N) begin
      lane_valid    <= '0;
      out_frame_age <= '0;
    end else if (state == ST_READ && rd_any) begin
      lane_valid    <= rd_lane_mask;
      out_frame_age <= rd_age;
    end else begin
      lane_valid    <= '0;
      out_frame_age <= '0;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_bank
    oflow_mem_buffer_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (BANK_DEPTH),
      .ADDR_W (BEAT_ADDR_W)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[k]),
      .addr  (bank_addr),
      .wdata (data_in[k*DATA_W +: DATA_W]),
      .rdata (bank_rdata[k])
    );
    assign data_out[k*DATA_W +: DATA_W] = lane_valid[k] ? bank_rdata[k] : '0;
  end

endmodule

// File: tb/tb_oflow_mem_buffer_multi_ch.sv
// Bench for oflow_mem_buffer_multi_ch: random frames checked against a
// newest-first frame list model with a separate history count.
module tb_oflow_mem_buffer_multi_ch;
  import oflow_mem_buffer_pkg::*;

  localparam int NUM_CH     = 2;
  localparam int DATA_W     = 32;
  localparam int MAX_BBOX   = 32;
  localparam int NUM_FRAMES = 5;
  localparam int CNT_W      = $clog2(MAX_BBOX + 1);
  localparam int HIST_W     = $clog2(NUM_FRAMES + 1);
  localparam int AGE_W      = $clog2(NUM_FRAMES);
  localparam int EXP_W      = NUM_CH + AGE_W + NUM_CH * DATA_W;

  // ---------------- clock / reset / DUT ----------------
  logic                       clk = 1'b0;
  logic                       reset_N = 1'b0;
  logic                       start_write = 1'b0;
  logic                       start_read = 1'b0;
  logic [CNT_W-1:0]           num_of_bbox_in_frame = '0;
  logic [HIST_W-1:0]          num_of_history_frames = '0;
  logic [NUM_CH*DATA_W-1:0]   data_in = '0;
  logic                       data_in_valid = 1'b0;
  logic                       in_ready;
  logic [NUM_CH*DATA_W-1:0]   data_out;
  logic [NUM_CH-1:0]          lane_valid;
  logic [AGE_W-1:0]           out_frame_age;
  logic                       done_write;
  logic                       done_read;
  logic [HIST_W-1:0]          hist_count;
  state_t                     dbg_state;

  always #5 clk = ~clk;

  oflow_mem_buffer_multi_ch #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_BBOX(MAX_BBOX), .NUM_FRAMES(NUM_FRAMES)
  ) dut (
    .clk                                   (clk),
    .reset_N                               (reset_N),
    .start_write                           (start_write),
    .start_read                            (start_read),
    .num_of_bbox_in_frame                  (num_of_bbox_in_frame),
    .num_of_history_frames                 (num_of_history_frames),
    .data_in                               (data_in),
    .data_in_valid                         (data_in_valid),
    .in_ready                              (in_ready),
    .data_out                              (data_out),
    .lane_valid                            (lane_valid),
    .out_frame_age                         (out_frame_age),
    .done_write                            (done_write),
    .done_read                             (done_read),
    .counter_of_history_frame_to_interface (hist_count),
    .dbg_state                             (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // m_words[a] / m_len[a] hold the a-th newest frame committed since reset.
  logic [DATA_W-1:0] m_words [NUM_FRAMES][MAX_BBOX];
  int                m_len   [NUM_FRAMES];
  int                m_count = 0;
  logic [DATA_W-1:0] wr_words [MAX_BBOX];
  logic [EXP_W-1:0]  exp_q [$];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    m_count = 0;
    for (int a = 0; a < NUM_FRAMES; a++) m_len[a] = 0;
  endtask

  task automatic model_commit(input int n, input int h);
    for (int a = NUM_FRAMES - 1; a > 0; a--) begin
      m_len[a]   = m_len[a-1];
      m_words[a] = m_words[a-1];
    end
    m_len[0] = n;
    for (int e = 0; e < MAX_BBOX; e++) m_words[0][e] = wr_words[e];
    m_count = imin(m_count + 1, imin(h, NUM_FRAMES));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_words(input logic [DATA_W-1:0] word0, input bit ramp);
    for (int e = 0; e < MAX_BBOX; e++)
      wr_words[e] = ramp ? word0 + DATA_W'(e) : ((e == 0) ? word0 : DATA_W'($urandom));
  endtask

  task automatic apply_reset(input int cycles);
    reset_N = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      start_write   = 1'($urandom);
      start_read    = 1'($urandom);
      data_in_valid = 1'($urandom);
      data_in       = {$urandom, $urandom};
      step();
    end
    reset_N = 1'b0; start_write = 1'b0; start_read = 1'b0; data_in_valid = 1'b0;
    model_clear();
  endtask

  // Writes a frame of n_req words from wr_words with random valid gaps.
  task automatic write_frame(input int n_req, input int h, input bit collide);
    int n, beats, b;
    logic accepted;
    n     = imin(n_req, MAX_BBOX);
    beats = (n + NUM_CH - 1) / NUM_CH;
    num_of_bbox_in_frame  = CNT_W'(n_req);
    num_of_history_frames = HIST_W'(h);
    start_write = 1'b1;
    start_read  = collide;
    step();
    start_write = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || dbg_state !== ST_WRITE) begin
      errors++;
      $display("FAIL write_entry: in_ready=%0b state=%0d required in_ready=1 state=%0d",
               in_ready, dbg_state, ST_WRITE);
    end
    num_of_bbox_in_frame = CNT_W'($urandom);
    b = 0;
    if (beats == 0) begin
      data_in_valid = 1'($urandom);
      data_in       = {$urandom, $urandom};
      step();
      start_read = 1'b0;
      checks++;
      if ({done_write, in_ready, lane_valid} !== {1'b1, 1'b0, {NUM_CH{1'b0}}}) begin
        errors++;
        $display("FAIL write_zero_done: done_write=%0b in_ready=%0b lane_valid=%b required 1/0/0",
                 done_write, in_ready, lane_valid);
      end
    end
    while (b < beats) begin
      if ($urandom_range(0, 3) == 0) begin
        data_in_valid = 1'b0;
        data_in       = {$urandom, $urandom};
        accepted      = 1'b0;
      end else begin
        data_in_valid = 1'b1;
        for (int k = 0; k < NUM_CH; k++)
          data_in[k*DATA_W +: DATA_W] = (b * NUM_CH + k < n) ? wr_words[b*NUM_CH+k] : DATA_W'($urandom);
        accepted = 1'b1;
        b++;
      end
      step();
      start_read = 1'b0;
      checks++;
      if (accepted && b == beats) begin
        if ({done_write, in_ready, lane_valid} !== {1'b1, 1'b0, {NUM_CH{1'b0}}}) begin
          errors++;
          $display("FAIL write_done: done_write=%0b in_ready=%0b lane_valid=%b required 1/0/0",
                   done_write, in_ready, lane_valid);
        end
      end else begin
        if ({done_write, in_ready, lane_valid} !== {1'b0, 1'b1, {NUM_CH{1'b0}}}) begin
          errors++;
          $display("FAIL write_beat: done_write=%0b in_ready=%0b lane_valid=%b required 0/1/0",
                   done_write, in_ready, lane_valid);
        end
      end
    end
    data_in_valid = 1'b0;
    model_commit(n, h);
    step();
    checks++;
    if ({done_write, done_read, lane_valid} !== '0 || dbg_state !== ST_IDLE ||
        hist_count !== HIST_W'(m_count)) begin
      errors++;
      $display("FAIL write_commit: done_w=%0b done_r=%0b lv=%b state=%0d count=%0d required 0/0/0 IDLE count=%0d",
               done_write, done_read, lane_valid, dbg_state, hist_count, m_count);
    end
  endtask

  // Streams the history and checks every cycle against the scoreboard queue.
  task automatic read_history(input int h);
    int nf, nb, iters;
    logic [NUM_CH-1:0]        lv;
    logic [NUM_CH*DATA_W-1:0] d, mask;
    logic [EXP_W-1:0]         exp_v, obs_v;
    nf = imin(m_count, imin(h, NUM_FRAMES));
    for (int a = 0; a < nf; a++) begin
      for (int b = 0; b < (m_len[a] + NUM_CH - 1) / NUM_CH; b++) begin
        lv = '0; d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
          if (b * NUM_CH + k < m_len[a]) begin
            lv[k] = 1'b1;
            d[k*DATA_W +: DATA_W] = m_words[a][b*NUM_CH+k];
          end
        end
        exp_q.push_back({lv, AGE_W'(a), d});
      end
    end
    nb = exp_q.size();
    num_of_history_frames = HIST_W'(h);
    start_read = 1'b1;
    step();
    start_read = 1'b0;
    num_of_history_frames = HIST_W'($urandom_range(0, 7));
    checks++;
    if (lane_valid !== '0 || done_read !== 1'b0 || dbg_state !== ST_READ) begin
      errors++;
      $display("FAIL read_entry: lane_valid=%b done_read=%0b state=%0d required 0/0/%0d",
               lane_valid, done_read, dbg_state, ST_READ);
    end
    iters = (nb == 0) ? 1 : nb;
    for (int i = 0; i < iters; i++) begin
      step();
      checks++;
      if (nb == 0) begin
        if (lane_valid !== '0 || done_read !== 1'b1) begin
          errors++;
          $display("FAIL read_empty: lane_valid=%b done_read=%0b required 0/1", lane_valid, done_read);
        end
      end else begin
        exp_v = exp_q.pop_front();
        mask  = '0;
        for (int k = 0; k < NUM_CH; k++)
          if (exp_v[EXP_W-NUM_CH+k]) mask[k*DATA_W +: DATA_W] = '1;
        obs_v = {lane_valid, out_frame_age, data_out & mask};
        if (obs_v !== exp_v || done_read !== (i == nb - 1)) begin
          errors++;
          $display("FAIL read_beat%0d: got %h done_read=%0b required %h done_read=%0b",
                   i, obs_v, done_read, exp_v, (i == nb - 1));
        end
      end
    end
    step();
    checks++;
    if (lane_valid !== '0 || done_read !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL read_tail: lane_valid=%b done_read=%0b state=%0d required 0/0/IDLE",
               lane_valid, done_read, dbg_state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset(3);
    checks++;
    if ({in_ready, data_out, lane_valid, out_frame_age, done_write, done_read, hist_count} !== '0 ||
        dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%0b dout=%h lv=%b age=%0d dw=%0b dr=%0b cnt=%0d state=%0d required all 0",
               in_ready, data_out, lane_valid, out_frame_age, done_write, done_read, hist_count, dbg_state);
    end
    step();
    checks++;
    if ({in_ready, lane_valid, done_write, done_read, hist_count} !== '0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_idle: in_ready=%0b lv=%b dw=%0b dr=%0b cnt=%0d state=%0d required all 0",
               in_ready, lane_valid, done_write, done_read, hist_count, dbg_state);
    end
  endtask

  task automatic test_basic();
    fill_words(32'hA0, 1'b1);
    write_frame(5, 5, 1'b0);
    read_history(5);
  endtask

  task automatic test_ring_wrap();
    apply_reset(2);
    for (int id = 0; id < 7; id++) begin
      fill_words(DATA_W'(id), 1'b0);
      write_frame((id == 3) ? 50 : $urandom_range(1, MAX_BBOX), 5, 1'b0);
    end
    checks++;
    if (hist_count !== HIST_W'(5)) begin
      errors++;
      $display("FAIL wrap_count: count=%0d required 5", hist_count);
    end
    read_history(5);
  endtask

  task automatic test_history_trunc();
    fill_words(32'hB0, 1'b1);
    write_frame($urandom_range(1, MAX_BBOX), 3, 1'b0);
    checks++;
    if (hist_count !== HIST_W'(3)) begin
      errors++;
      $display("FAIL trunc_count: count=%0d required 3", hist_count);
    end
    read_history(3);
    read_history(7);
    fill_words(32'hC0, 1'b1);
    write_frame(MAX_BBOX, 5, 1'b0);
    read_history(5);
  endtask

  task automatic test_collision();
    fill_words(32'hD0, 1'b1);
    write_frame(7, 5, 1'b1);
    read_history(5);
  endtask

  task automatic test_zero_bbox();
    apply_reset(1);
    fill_words(32'hE0, 1'b1);
    write_frame(3, 5, 1'b0);
    fill_words(32'hF0, 1'b1);
    write_frame(0, 5, 1'b0);
    read_history(5);
    fill_words(32'h100, 1'b1);
    write_frame(4, 5, 1'b0);
    read_history(5);
  endtask

  task automatic test_reset_mid_write();
    apply_reset(1);
    num_of_bbox_in_frame  = CNT_W'(8);
    num_of_history_frames = HIST_W'(5);
    start_write = 1'b1;
    step();
    start_write = 1'b0;
    for (int b = 0; b < 2; b++) begin
      data_in_valid = 1'b1;
      data_in       = {$urandom, $urandom};
      step();
    end
    data_in_valid = 1'b0;
    reset_N = 1'b1;
    step();
    checks++;
    if (done_write !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done_write=%0b required 0", done_write);
    end
    reset_N = 1'b0;
    model_clear();
    step();
    checks++;
    if (hist_count !== '0 || done_write !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL abort_state: count=%0d done_write=%0b state=%0d required 0/0/IDLE",
               hist_count, done_write, dbg_state);
    end
    read_history(5);
  endtask

  task automatic test_random();
    apply_reset(1);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        fill_words(DATA_W'($urandom), 1'b0);
        write_frame($urandom_range(0, 40), $urandom_range(0, 7), 1'($urandom));
      end else begin
        read_history($urandom_range(0, 7));
      end
    end
    read_history(5);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_ring_wrap();
    test_history_trunc();
    test_collision();
    test_zero_bbox();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oflow_mem_buffer_multi_ch.md
# oflow_mem_buffer_multi_ch

Parametrised history-frame buffer between the core FSM and the PE array in the oflow tracking datapath. It stores the feature words of the last `NUM_FRAMES` frames in a ring of frame slots. Each frame is written NUM_CH words per beat. On request, it streams all valid history frames back to the PEs, newest first, with per-lane valid flags. It replaces the fixed 2-lane buffer plus separate FSM with one block generalised in lane count, word width, bbox depth and history depth, and adds per-slot bbox bookkeeping.

## Interface
- NUM_CH, 2, PE lanes served per beat.
- DATA_W, 32, feature word width.
- MAX_BBOX, 32, max bboxes per frame; must be a multiple of NUM_CH.
- NUM_FRAMES, 5, history slots in the ring.
- clk  in  1  single clock.
- reset_N  in  1  synchronous, active-high reset (the port keeps the codebase name; asserted = 1).
- start_write  in  1  core FSM pulse: begin capturing the current frame.
- start_read  in  1  core FSM pulse: begin streaming history.
- num_of_bbox_in_frame  in  $clog2(MAX_BBOX+1)  word count of the frame being written.
- num_of_history_frames  in  $clog2(NUM_FRAMES+1)  fallback depth: max frames retained and read.
- data_in  in  NUM_CH*DATA_W  write beat; lane k is bits [k*DATA_W +: DATA_W].
- data_in_valid  in  1  beat present.
- in_ready  out  1  high in WRITE; a beat is accepted when data_in_valid && in_ready.
- data_out  out  NUM_CH*DATA_W  read beat.
- lane_valid  out  NUM_CH  per-lane validity of data_out.
- out_frame_age  out  $clog2(NUM_FRAMES)  0 = newest stored frame.
- done_write  out  1  one-cycle pulse, frame committed.
- done_read  out  1  one-cycle pulse, history stream finished.
- counter_of_history_frame_to_interface  out  $clog2(NUM_FRAMES+1)  number of valid stored frames.

## Operation
- States: IDLE, WRITE, READ, DONE_W, DONE_R.
  - IDLE→WRITE on start_write.
  - IDLE→READ on start_read.
  - If both are asserted in the same cycle, start_write wins and start_read is dropped.
  - Starts arriving outside IDLE are ignored.
- WRITE
  - Latch n = min(num_of_bbox_in_frame, MAX_BBOX) on entry.
  - Each accepted beat writes word e (lane e%NUM_CH) to bank e%NUM_CH, address wr_slot*(MAX_BBOX/NUM_CH) + e/NUM_CH.
  - Lanes with e ≥ n are not written.
  - When ceil(n/NUM_CH) beats have been accepted, go to DONE_W.
  - If n = 0, go to DONE_W the cycle after entry.
- DONE_W (one cycle)
  - done_write=1.
  - bbox_cnt[wr_slot] ← n.
  - wr_slot ← (wr_slot+1) mod NUM_FRAMES.
  - history count ← min(count+1, H), where H = min(num_of_history_frames, NUM_FRAMES).
  - Return to IDLE.
- READ
  - Latch H on entry.
  - For age a = 0 .. count−1, read slot (wr_slot−1−a) mod NUM_FRAMES: ceil(bbox_cnt/NUM_CH) beats, one per cycle, no stall.
  - Slots with bbox_cnt = 0 produce no beats.
  - After the last beat issues, go to DONE_R.
  - If count = 0, go to DONE_R immediately.
- DONE_R: done_read=1 for one cycle, then IDLE.
- Lowering num_of_history_frames below the current count truncates the count to the new H on the next commit. Reads use min(count, H).
- Stored data is unchanged by reset. Only pointers, count and bbox_cnt are cleared.

## Timing
- Reset, and the cycle after reset deasserts:
  - all outputs are 0;
  - state=IDLE, wr_slot=0, count=0, every bbox_cnt=0.
- Reset mid-WRITE or mid-READ aborts the operation. No done pulse is generated, and a partially written frame is not committed.
- in_ready rises the cycle after start_write.
- done_write is asserted the cycle after the last beat is accepted.
- Read latency is 1 cycle: an address issued in cycle t gives data_out/lane_valid/out_frame_age valid in t+1.
- Beats are back-to-back.
- done_read is coincident with the final data beat. With an empty history, done_read comes 2 cycles after start_read.
- lane_valid is 0 whenever no beat is presented. data_out is don't-care while lane_valid=0.
- Ring wrap: after NUM_FRAMES commits, the oldest slot is overwritten and count saturates.

## Structure
- Package oflow_mem_buffer_pkg holds:
  - the state enum;
  - width helper localparams (SLOT_W, WORD_IDX_W, BEAT_ADDR_W = $clog2(NUM_FRAMES*MAX_BBOX/NUM_CH)).
- Sub-module oflow_mem_buffer_bank: single-port synchronous RAM, DATA_W × NUM_FRAMES*MAX_BBOX/NUM_CH, registered read. One instance per lane via generate.
- The FSM, pointers and the bbox_cnt array live in the top.

## Test plan
- Reset, then write a frame (NUM_CH=2, n=5, words 0xA0..0xA4), then read.
  - done_write follows 3 accepted beats.
  - Read gives 3 beats: lane_valid 11, 11, 01; age 0; done_read on the 3rd beat.
- Write 7 frames with NUM_FRAMES=5, H=5, word0 = frame id.
  - count saturates at 5.
  - Read returns ids 6, 5, 4, 3, 2 with ages 0–4.
- H=3 after 5 frames are stored.
  - The next commit sets count=3.
  - Read returns only ages 0–2.
- start_write and start_read in the same cycle.
  - WRITE is entered and no read beats appear.
  - start_read during WRITE is ignored.
- Zero-bbox frame followed by start_read.
  - done_write 2 cycles after start_write.
  - The empty slot yields no beats, but count still increments.
- reset_N asserted after 2 of 4 write beats.
  - No done_write; count=0.
  - A subsequent read gives done_read with no beats.
